// File: rtl/fta_bus_pkg.sv
// FTA bus request/response types shared by the CPU-side and device-side bridge
// logic, plus the I/O bridge tracker entry and small response helpers.
package fta_bus_pkg;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [3:0]   cid;
    logic [7:0]   tid;
    logic [31:0]  padr;
    logic [1:0]   bte;
    logic [2:0]   cti;
    logic [15:0]  sel;
    logic [127:0] data1;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  cid;
    logic [7:0]  tid;
    logic [31:0] padr;
    logic [1:0]  bte;
    logic [2:0]  cti;
    logic [7:0]  sel;
    logic [63:0] dat;
  } fta_cmd_request64_t;

  typedef struct packed {
    logic         ack;
    logic         err;
    logic         rty;
    logic         stall;
    logic [3:0]   cid;
    logic [7:0]   tid;
    logic [31:0]  adr;
    logic [3:0]   pri;
    logic [127:0] dat;
  } fta_cmd_response128_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        rty;
    logic        stall;
    logic [3:0]  cid;
    logic [7:0]  tid;
    logic [31:0] adr;
    logic [3:0]  pri;
    logic [63:0] dat;
  } fta_cmd_response64_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  tid;
    logic [3:0]  cid;
    logic        hi_lane;
    logic [15:0] age;
  } io_trk_entry_t;

  // Idle device-side request: the all-ones address keeps decoders off any real device.
  localparam fta_cmd_request64_t FTA_REQ64_IDLE = '{
    cyc: 1'b0, stb: 1'b0, we: 1'b0, cid: 4'd0, tid: 8'd0, padr: 32'hFFFF_FFFF,
    bte: 2'b00, cti: 3'b000, sel: 8'h00, dat: 64'd0
  };

  function automatic fta_cmd_response128_t fta_err_resp(input logic [7:0] tid,
                                                        input logic [3:0] cid);
    fta_cmd_response128_t r;
    r     = '0;
    r.err = 1'b1;
    r.tid = tid;
    r.cid = cid;
    return r;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/fta_rr_arb.sv
// N-way round-robin arbiter: one-hot grant starting at the pointer; the pointer
// moves to grant+1 (mod N) whenever something is granted.
module fta_rr_arb #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  logic [PW-1:0] r_ptr;

  // NOTE: combinational blocks use blocking assignments and set every output to a
  // default first, so the search reads top to bottom and no latch is inferred.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_valid && i_req[(int'(r_ptr) + k) % N]) begin
        o_valid                             = 1'b1;
        o_grant[(int'(r_ptr) + k) % N]      = 1'b1;
        o_idx                               = PW'((int'(r_ptr) + k) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_valid) begin
      r_ptr <= (o_idx == PW'(N - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/io_bridge_fta_nch.sv
// Registered 128-bit CPU to 64-bit I/O bus bridge with a tid-indexed tracker,
// NCH captured response channels, round-robin return path and per-entry timeout.
module io_bridge_fta_nch
  import fta_bus_pkg::*;
#(
  parameter int          NCH     = 4,
  parameter int          DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023,
  parameter logic [31:0] IO_MASK = 32'hFFF0_0000,
  parameter logic [31:0] IO_BASE = 32'hFEE0_0000
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  fta_cmd_request128_t            s_req,
  output fta_cmd_response128_t           s_resp,
  output fta_cmd_request64_t             m_req,
  input  fta_cmd_response64_t [NCH-1:0]  ch_resp,
  output logic                           busy_o,
  output logic [15:0]                    timeout_cnt_o,
  output logic [15:0]                    orphan_cnt_o
);

  localparam int          IW     = $clog2(DEPTH);
  localparam int          CW     = $clog2(NCH);
  localparam logic [15:0] TO_AGE = 16'(TIMEOUT);

  io_trk_entry_t        r_trk [DEPTH];
  logic [DEPTH-1:0]     r_to_pend;
  logic                 r_full;
  logic                 r_bad_pend;
  logic [7:0]           r_bad_tid;
  logic [3:0]           r_bad_cid;
  fta_cmd_response64_t  r_ch [NCH];
  logic [NCH-1:0]       r_ch_v;
  fta_cmd_request64_t   r_mreq;
  fta_cmd_response128_t r_resp;
  logic [15:0]          r_to_cnt;
  logic [15:0]          r_orph_cnt;

  // ---------------- request side ----------------
  logic w_region, w_hi, w_lo, w_stall, w_req, w_bad, w_acc;

  assign w_stall  = r_full | r_bad_pend | (|r_to_pend);
  assign w_region = ((s_req.padr & IO_MASK) == (IO_BASE & IO_MASK));
  assign w_hi     = |s_req.sel[15:8];
  assign w_lo     = |s_req.sel[7:0];
  assign w_req    = s_req.cyc & s_req.stb & w_region & ~w_stall;
  assign w_bad    = w_req & (w_hi == w_lo);
  assign w_acc    = w_req & (w_hi ^ w_lo);

  // ---------------- response channels ----------------
  logic [NCH-1:0]      w_ch_in, w_gnt;
  logic [CW-1:0]       w_gnt_idx;
  logic                w_gnt_any;
  fta_cmd_response64_t w_g_resp;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_ch_in[c] = ch_resp[c].ack | ch_resp[c].err | ch_resp[c].rty;
    end
  end

  fta_rr_arb #(.N(NCH)) u_arb (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .i_req   (r_ch_v),
    .o_grant (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_any)
  );

  assign w_g_resp = r_ch[w_gnt_idx];

  // ---------------- tracker ----------------
  logic [DEPTH-1:0] w_free, w_to_new, w_to_all, w_valid_n, w_to_pend_n;
  logic [IW-1:0]    w_alloc_idx, w_hit_idx, w_to_idx;
  logic             w_hit, w_to_any, w_sel_to;
  logic [15:0]      w_to_num;

  always_comb begin
    w_alloc_idx = '0;
    w_hit_idx   = '0;
    w_hit       = 1'b0;
    w_to_idx    = '0;
    w_to_any    = 1'b0;
    w_to_num    = '0;
    w_free      = '0;
    w_to_new    = '0;
    // Descending scans so the lowest matching index is the one left standing.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_free[i] = ~r_trk[i].valid & ~r_to_pend[i];
      if (w_free[i]) w_alloc_idx = IW'(i);
      if (w_gnt_any && r_trk[i].valid && (r_trk[i].tid == w_g_resp.tid)) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
    end
    // A real response beats a same-cycle timeout on the same entry.
    for (int i = 0; i < DEPTH; i++) begin
      w_to_new[i] = r_trk[i].valid && (r_trk[i].age == TO_AGE) &&
                    !(w_hit && (w_hit_idx == IW'(i)));
      if (w_to_new[i]) w_to_num = w_to_num + 16'd1;
    end
    w_to_all = r_to_pend | w_to_new;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_to_all[i]) begin
        w_to_any = 1'b1;
        w_to_idx = IW'(i);
      end
    end
    // Return-path priority: device response, held bad-sel err, new bad-sel err, timeout err.
    w_sel_to    = w_to_any & ~w_hit & ~r_bad_pend & ~w_bad;
    w_to_pend_n = w_to_all;
    if (w_sel_to) w_to_pend_n[w_to_idx] = 1'b0;
    for (int i = 0; i < DEPTH; i++) w_valid_n[i] = r_trk[i].valid & ~w_to_new[i];
    if (w_hit) w_valid_n[w_hit_idx] = 1'b0;
    if (w_acc) w_valid_n[w_alloc_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the tracker and channel holding registers are a few flops, not a RAM,
      // so every entry is cleared and no stale valid bit can survive reset.
      for (int i = 0; i < DEPTH; i++) r_trk[i] <= '0;
      for (int c = 0; c < NCH; c++) r_ch[c] <= '0;
      r_ch_v     <= '0;
      r_to_pend  <= '0;
      r_full     <= 1'b0;
      r_bad_pend <= 1'b0;
      r_bad_tid  <= '0;
      r_bad_cid  <= '0;
      r_mreq     <= FTA_REQ64_IDLE;
      r_resp     <= '0;
      r_to_cnt   <= '0;
      r_orph_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_trk[i].valid <= w_valid_n[i];
        if (w_acc && (w_alloc_idx == IW'(i))) begin
          r_trk[i] <= '{valid: 1'b1, tid: s_req.tid, cid: s_req.cid,
                        hi_lane: w_hi, age: 16'd0};
        end else if (w_to_new[i]) begin
          r_trk[i].age <= '0;
        end else if (r_trk[i].valid) begin
          r_trk[i].age <= r_trk[i].age + 16'd1;
        end
      end
      r_to_pend <= w_to_pend_n;
      r_full    <= &(w_valid_n | w_to_pend_n);

      if (r_bad_pend && !w_hit) begin
        r_bad_pend <= 1'b0;
      end else if (w_bad && w_hit) begin
        r_bad_pend <= 1'b1;
        r_bad_tid  <= s_req.tid;
        r_bad_cid  <= s_req.cid;
      end

      r_resp <= '0;
      if (w_hit) begin
        r_resp <= '{ack: w_g_resp.ack, err: w_g_resp.err, rty: w_g_resp.rty, stall: 1'b0,
                    cid: w_g_resp.cid, tid: w_g_resp.tid, adr: w_g_resp.adr,
                    pri: w_g_resp.pri, dat: {w_g_resp.dat, w_g_resp.dat}};
      end else if (r_bad_pend) begin
        r_resp <= fta_err_resp(r_bad_tid, r_bad_cid);
      end else if (w_bad) begin
        r_resp <= fta_err_resp(s_req.tid, s_req.cid);
      end else if (w_sel_to) begin
        r_resp <= fta_err_resp(r_trk[w_to_idx].tid, r_trk[w_to_idx].cid);
      end

      if (w_acc) begin
        r_mreq <= '{cyc: 1'b1, stb: 1'b1, we: s_req.we, cid: s_req.cid, tid: s_req.tid,
                    padr: s_req.padr, bte: s_req.bte, cti: s_req.cti,
                    sel: s_req.sel[15:8] | s_req.sel[7:0],
                    dat: w_hi ? s_req.data1[127:64] : s_req.data1[63:0]};
      end else begin
        r_mreq <= FTA_REQ64_IDLE;
      end

      for (int c = 0; c < NCH; c++) begin
        if (w_ch_in[c] && (!r_ch_v[c] || w_gnt[c])) begin
          r_ch[c]   <= ch_resp[c];
          r_ch_v[c] <= 1'b1;
        end else if (w_gnt[c]) begin
          r_ch_v[c] <= 1'b0;
        end
      end

      r_to_cnt <= sat_add16(r_to_cnt, w_to_num);
      if (w_gnt_any && !w_hit) r_orph_cnt <= sat_add16(r_orph_cnt, 16'd1);
    end
  end

  // Both halves carry the device data, so the lane flag and device stall are informational.
  logic w_unused;
  always_comb begin
    w_unused = r_resp.stall;
    for (int c = 0; c < NCH; c++) w_unused = w_unused ^ r_ch[c].stall;
    for (int i = 0; i < DEPTH; i++) w_unused = w_unused ^ r_trk[i].hi_lane;
  end

  always_comb begin
    s_resp       = r_resp;
    s_resp.stall = w_stall;
  end

  assign m_req         = r_mreq;
  assign timeout_cnt_o = r_to_cnt;
  assign orphan_cnt_o  = r_orph_cnt;

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_o = busy_o | r_trk[i].valid;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chk
    a_no_overrun: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_ch_in[c] && r_ch_v[c] && !w_gnt[c]));
  end

endmodule

// File: tb/tb_io_bridge_fta_nch.sv
// Directed bench for io_bridge_fta_nch: forward path, lane steering, full stall,
// timeout, round-robin return, orphans, bad sel and asynchronous reset.
module tb_io_bridge_fta_nch;
  import fta_bus_pkg::*;

  localparam int NCH = 4;

  logic                          clk_i  = 1'b0;
  logic                          rst_ni = 1'b0;
  fta_cmd_request128_t           s_req;
  fta_cmd_response128_t          s_resp;
  fta_cmd_request64_t            m_req;
  fta_cmd_response64_t [NCH-1:0] ch_resp;
  logic                          busy_o;
  logic [15:0]                   timeout_cnt_o;
  logic [15:0]                   orphan_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  io_bridge_fta_nch #(
    .NCH(NCH), .DEPTH(4), .TIMEOUT(15),
    .IO_MASK(32'hFFF0_0000), .IO_BASE(32'hFEE0_0000)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .s_req         (s_req),
    .s_resp        (s_resp),
    .m_req         (m_req),
    .ch_resp       (ch_resp),
    .busy_o        (busy_o),
    .timeout_cnt_o (timeout_cnt_o),
    .orphan_cnt_o  (orphan_cnt_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] padr, input logic [15:0] sel,
                           input logic [127:0] data1, input logic [7:0] tid,
                           input logic [3:0] cid);
    s_req = '{cyc: 1'b1, stb: 1'b1, we: we, cid: cid, tid: tid, padr: padr,
              bte: 2'b00, cti: 3'b000, sel: sel, data1: data1};
  endtask

  function automatic fta_cmd_response64_t mk_ack(input logic [7:0] tid, input logic [63:0] dat);
    fta_cmd_response64_t r;
    r     = '0;
    r.ack = 1'b1;
    r.tid = tid;
    r.dat = dat;
    return r;
  endfunction

  task automatic test_reset();
    s_req   = '0;
    ch_resp = '0;
    #12;
    n_tests++; if (m_req !== FTA_REQ64_IDLE) begin n_fail++; $display("FAIL reset_m_req: got %h expected %h", m_req, FTA_REQ64_IDLE); end
    n_tests++; if (s_resp !== '0) begin n_fail++; $display("FAIL reset_s_resp: got %h expected 0", s_resp); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_tests++; if (timeout_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_to_cnt: got %0d expected 0", timeout_cnt_o); end
    n_tests++; if (orphan_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_orphan_cnt: got %0d expected 0", orphan_cnt_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_arb();
    drive_req(1'b0, 32'hFEE0_0000, 16'h000F, '0, 8'd1, 4'd0); tick();
    drive_req(1'b0, 32'hFEE0_0008, 16'h000F, '0, 8'd2, 4'd0); tick();
    drive_req(1'b0, 32'hFEE0_0010, 16'h000F, '0, 8'd3, 4'd0); tick();
    s_req = '0;
    n_tests++; if (m_req.tid !== 8'd3) begin n_fail++; $display("FAIL arb_alloc_tid: got %0d expected 3", m_req.tid); end
    ch_resp    = '0;
    ch_resp[0] = mk_ack(8'd1, 64'h1);
    ch_resp[2] = mk_ack(8'd2, 64'h2);
    ch_resp[3] = mk_ack(8'd3, 64'h3);
    tick();
    ch_resp = '0;
    tick();
    n_tests++; if (s_resp.ack !== 1'b1 || s_resp.tid !== 8'd1) begin n_fail++; $display("FAIL arb_first: got ack=%b tid=%0d expected ack=1 tid=1", s_resp.ack, s_resp.tid); end
    tick();
    n_tests++; if (s_resp.ack !== 1'b1 || s_resp.tid !== 8'd2) begin n_fail++; $display("FAIL arb_second: got ack=%b tid=%0d expected ack=1 tid=2", s_resp.ack, s_resp.tid); end
    tick();
    n_tests++; if (s_resp.ack !== 1'b1 || s_resp.tid !== 8'd3) begin n_fail++; $display("FAIL arb_third: got ack=%b tid=%0d expected ack=1 tid=3", s_resp.ack, s_resp.tid); end
    tick();
    n_tests++; if (s_resp.ack !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL arb_drained: got ack=%b busy=%b expected 0 0", s_resp.ack, busy_o); end
    // Pointer is back at 0 after the ch3 grant, so ch0 wins the next contention.
    drive_req(1'b0, 32'hFEE0_0020, 16'h000F, '0, 8'd4, 4'd0); tick();
    drive_req(1'b0, 32'hFEE0_0028, 16'h000F, '0, 8'd7, 4'd0); tick();
    s_req      = '0;
    ch_resp[3] = mk_ack(8'd7, 64'h7);
    ch_resp[0] = mk_ack(8'd4, 64'h4);
    tick();
    ch_resp = '0;
    tick();
    n_tests++; if (s_resp.tid !== 8'd4) begin n_fail++; $display("FAIL arb_wrap_first: got tid=%0d expected 4", s_resp.tid); end
    tick();
    n_tests++; if (s_resp.tid !== 8'd7) begin n_fail++; $display("FAIL arb_wrap_second: got tid=%0d expected 7", s_resp.tid); end
    tick();
  endtask

  task automatic test_read();
    drive_req(1'b0, 32'hFEE0_0010, 16'h00F0, '0, 8'd5, 4'd2);
    tick();
    s_req = '0;
    n_tests++; if (m_req.cyc !== 1'b1 || m_req.sel !== 8'hF0 || m_req.tid !== 8'd5 || m_req.we !== 1'b0) begin n_fail++; $display("FAIL read_fwd: got cyc=%b sel=%h tid=%0d we=%b expected 1 f0 5 0", m_req.cyc, m_req.sel, m_req.tid, m_req.we); end
    n_tests++; if (m_req.padr !== 32'hFEE0_0010) begin n_fail++; $display("FAIL read_padr: got %h expected fee00010", m_req.padr); end
    n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %b expected 1", busy_o); end
    ch_resp[1] = mk_ack(8'd5, 64'h1122334455667788);
    tick();
    ch_resp = '0;
    n_tests++; if (m_req.cyc !== 1'b0 || s_resp.ack !== 1'b0) begin n_fail++; $display("FAIL read_one_shot: got cyc=%b ack=%b expected 0 0", m_req.cyc, s_resp.ack); end
    tick();
    n_tests++; if (s_resp.ack !== 1'b1 || s_resp.tid !== 8'd5) begin n_fail++; $display("FAIL read_resp: got ack=%b tid=%0d expected 1 5", s_resp.ack, s_resp.tid); end
    n_tests++; if (s_resp.dat !== 128'h11223344556677881122334455667788) begin n_fail++; $display("FAIL read_dat: got %h expected 11223344556677881122334455667788", s_resp.dat); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL read_freed: got busy=%b expected 0", busy_o); end
    tick();
  endtask

  task automatic test_write();
    drive_req(1'b1, 32'hFEE0_0040, 16'hFF00,
              {64'hDEADBEEF_00000000, 64'h0123_4567_89AB_CDEF}, 8'd6, 4'd1);
    tick();
    s_req = '0;
    n_tests++; if (m_req.sel !== 8'hFF || m_req.we !== 1'b1) begin n_fail++; $display("FAIL write_sel_we: got sel=%h we=%b expected ff 1", m_req.sel, m_req.we); end
    n_tests++; if (m_req.dat !== 64'hDEADBEEF_00000000) begin n_fail++; $display("FAIL write_dat: got %h expected deadbeef00000000", m_req.dat); end
    ch_resp[0] = mk_ack(8'd6, 64'hCAFE_F00D_0000_0001);
    tick();
    ch_resp = '0;
    tick();
    n_tests++; if (s_resp.ack !== 1'b1 || s_resp.dat !== {2{64'hCAFE_F00D_0000_0001}}) begin n_fail++; $display("FAIL write_resp: got ack=%b dat=%h expected 1 cafef00d00000001cafef00d00000001", s_resp.ack, s_resp.dat); end
    tick();
  endtask

  task automatic test_full();
    int acks;
    for (int k = 0; k < 4; k++) begin
      drive_req(1'b0, 32'hFEE0_0100, 16'h000F, '0, 8'(10 + k), 4'd0);
      tick();
    end
    n_tests++; if (s_resp.stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b expected 1", s_resp.stall); end
    drive_req(1'b0, 32'hFEE0_0100, 16'h000F, '0, 8'd14, 4'd0);
    tick();
    n_tests++; if (m_req.cyc !== 1'b0) begin n_fail++; $display("FAIL full_held: got cyc=%b expected 0", m_req.cyc); end
    ch_resp[2] = mk_ack(8'd10, 64'hA);
    tick();
    ch_resp = '0;
    tick();
    n_tests++; if (s_resp.ack !== 1'b1 || s_resp.tid !== 8'd10 || s_resp.stall !== 1'b0) begin n_fail++; $display("FAIL full_free: got ack=%b tid=%0d stall=%b expected 1 10 0", s_resp.ack, s_resp.tid, s_resp.stall); end
    tick();
    s_req = '0;
    n_tests++; if (m_req.cyc !== 1'b1 || m_req.tid !== 8'd14 || s_resp.stall !== 1'b1) begin n_fail++; $display("FAIL full_fifth: got cyc=%b tid=%0d stall=%b expected 1 14 1", m_req.cyc, m_req.tid, s_resp.stall); end
    for (int c = 0; c < NCH; c++) ch_resp[c] = mk_ack(8'(11 + c), 64'(c));
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      ch_resp = '0;
      if (s_resp.ack) acks++;
    end
    n_tests++; if (acks != 4 || busy_o !== 1'b0) begin n_fail++; $display("FAIL full_drain: got acks=%0d busy=%b expected 4 0", acks, busy_o); end
  endtask

  task automatic test_timeout();
    drive_req(1'b0, 32'hFEE0_0200, 16'h000F, '0, 8'd9, 4'd4);
    tick();
    s_req = '0;
    n_tests++; if (m_req.tid !== 8'd9) begin n_fail++; $display("FAIL to_fwd: got tid=%0d expected 9", m_req.tid); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        n_tests++; if (s_resp.err !== 1'b0) begin n_fail++; $display("FAIL to_early: got err=%b expected 0", s_resp.err); end
      end
    end
    n_tests++; if (s_resp.err !== 1'b1 || s_resp.tid !== 8'd9 || s_resp.cid !== 4'd4) begin n_fail++; $display("FAIL to_err: got err=%b tid=%0d cid=%0d expected 1 9 4", s_resp.err, s_resp.tid, s_resp.cid); end
    n_tests++; if (timeout_cnt_o !== 16'd1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL to_count: got cnt=%0d busy=%b expected 1 0", timeout_cnt_o, busy_o); end
    tick();
  endtask

  task automatic test_orphan();
    ch_resp[2] = mk_ack(8'd77, 64'h77);
    tick();
    ch_resp = '0;
    tick();
    n_tests++; if (s_resp.ack !== 1'b0 || orphan_cnt_o !== 16'd1) begin n_fail++; $display("FAIL orphan: got ack=%b cnt=%0d expected 0 1", s_resp.ack, orphan_cnt_o); end
    tick();
  endtask

  task automatic test_bad_sel();
    drive_req(1'b0, 32'hFEE0_0100, 16'h0101, '0, 8'd33, 4'd3);
    tick();
    s_req = '0;
    n_tests++; if (m_req.cyc !== 1'b0) begin n_fail++; $display("FAIL mixed_not_fwd: got cyc=%b expected 0", m_req.cyc); end
    n_tests++; if (s_resp.err !== 1'b1 || s_resp.tid !== 8'd33 || s_resp.cid !== 4'd3) begin n_fail++; $display("FAIL mixed_err: got err=%b tid=%0d cid=%0d expected 1 33 3", s_resp.err, s_resp.tid, s_resp.cid); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mixed_no_alloc: got busy=%b expected 0", busy_o); end
    drive_req(1'b0, 32'hFEE0_0100, 16'h0000, '0, 8'd34, 4'd0);
    tick();
    s_req = '0;
    n_tests++; if (s_resp.err !== 1'b1 || s_resp.tid !== 8'd34 || m_req.cyc !== 1'b0) begin n_fail++; $display("FAIL zero_sel: got err=%b tid=%0d cyc=%b expected 1 34 0", s_resp.err, s_resp.tid, m_req.cyc); end
    drive_req(1'b0, 32'h1000_0000, 16'h000F, '0, 8'd35, 4'd0);
    tick();
    s_req = '0;
    n_tests++; if (m_req.cyc !== 1'b0 || s_resp.err !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL region_miss: got cyc=%b err=%b busy=%b expected 0 0 0", m_req.cyc, s_resp.err, busy_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive_req(1'b0, 32'hFEE0_0300, 16'h000F, '0, 8'd20, 4'd0);
    tick();
    s_req = '0;
    n_tests++; if (busy_o !== 1'b1 || m_req.cyc !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got busy=%b cyc=%b expected 1 1", busy_o, m_req.cyc); end
    #2;
    rst_ni = 1'b0;
    #1;
    n_tests++; if (m_req !== FTA_REQ64_IDLE) begin n_fail++; $display("FAIL mid_m_req: got %h expected %h", m_req, FTA_REQ64_IDLE); end
    n_tests++; if (s_resp !== '0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_s_resp: got %h busy=%b expected 0 0", s_resp, busy_o); end
    n_tests++; if (timeout_cnt_o !== 16'd0 || orphan_cnt_o !== 16'd0) begin n_fail++; $display("FAIL mid_counters: got to=%0d orphan=%0d expected 0 0", timeout_cnt_o, orphan_cnt_o); end
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_arb();
    test_read();
    test_write();
    test_full();
    test_timeout();
    test_orphan();
    test_bad_sel();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
